mips_mc_controller: RTL
=======================

// Module: mips_mc_controller
// PURPOSE
//  Multicycle main controller for the 8-bit MIPS core. Sequences the datapath that fetches a 32-bit
//  instruction as four byte reads, decodes it, executes it, then writes back.
//  Moore FSM plus ALU-function decode. Drives every datapath enable and mux select.
//  Sits beside the datapath in the top-level cpu; inputs are instr[31:26], instr[5:0] and ALU zero.
// PARAMETERS
//  ILLEGAL_TRAP  0  1: unknown opcode enters HALT until reset; 0: unknown opcode is a NOP (back to FETCH1)
// PORTS
//  clk         in   1  single system clock, all state updates on posedge
//  reset       in   1  synchronous, active-high
//  op          in   6  instr[31:26]
//  funct       in   6  instr[5:0]
//  zero        in   1  ALU result == 0 (combinational from datapath)
//  memwrite    out  1  memory write strobe
//  pcen        out  1  PC register enable = pcwrite | (branch & zero)
//  iord        out  1  0: address=pc, 1: address=aluout
//  alusrcA     out  1  0: pc, 1: A
//  alusrcB     out  2  00 writedata(B), 01 const 1, 10 imm, 11 imm<<2
//  pcsrc       out  2  00 aluresult, 01 aluout, 10 jump target (immx4)
//  irwrite     out  4  one-hot byte enable for instruction register
//  regwrite    out  1  register file write
//  regdst      out  1  0: rt, 1: rd
//  memtoreg    out  1  0: aluout, 1: data
//  alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  halted      out  1  high in HALT state (only reachable if ILLEGAL_TRAP=1)
// BEHAVIOUR
//  - reset=1 at posedge: state <= FETCH1. While reset=1: memwrite, regwrite, pcen and irwrite are forced to 0.
//    All other outputs show FETCH1 decode.
//  - Outputs are pure functions of state, except pcen (zero) and alucontrol (funct).
//    Unlisted outputs are 0 in every state.
//  - FETCH1..4: iord=0, alusrcA=0, alusrcB=01, pcsrc=00, pcwrite=1, irwrite=0001/0010/0100/1000.
//    PC increments by 1 per byte. FETCHn -> FETCHn+1; FETCH4 -> DECODE.
//  - DECODE: alusrcA=0, alusrcB=11, aluop=add. Computes the branch target into aluout. Next state by op:
//    LB 100000 / SB 101000 -> MEMADR; RTYPE 000000 -> RTYPEEX; BEQ 000100 -> BEQEX;
//    J 000010 -> JEX; ADDI 001000 -> ADDIEX; other -> FETCH1 (or HALT if ILLEGAL_TRAP).
//  - MEMADR: alusrcA=1, alusrcB=10, add. LB -> LBRD, SB -> SBWR.
//  - LBRD: iord=1 -> LBWR.
//  - LBWR: regwrite=1, memtoreg=1, regdst=0 -> FETCH1.
//  - SBWR: iord=1, memwrite=1 -> FETCH1.
//  - RTYPEEX: alusrcA=1, alusrcB=00, aluop=funct -> RTYPEWR.
//  - RTYPEWR: regwrite=1, regdst=1, memtoreg=0 -> FETCH1.
//  - BEQEX: alusrcA=1, alusrcB=00, sub, branch=1, pcsrc=01 -> FETCH1. PC loads only if zero=1 in this cycle.
//  - JEX: pcwrite=1, pcsrc=10 -> FETCH1.
//  - ADDIEX: alusrcA=1, alusrcB=10, add -> ADDIWR.
//  - ADDIWR: regwrite=1, regdst=0, memtoreg=0 -> FETCH1.
//  - HALT: all strobes 0, halted=1; exits only via reset.
//  - Latency (cycles incl. fetch): LB 8, SB 7, R 7, ADDI 7, BEQ 6, J 6.
//  - ALU decode: aluop add -> 010, sub -> 110, funct -> add 100000:010, sub 100010:110, and 100100:000,
//    or 100101:001, slt 101010:111. Unknown funct -> 010; no trap, instruction still writes back.
//  - op and funct are sampled only in DECODE, MEMADR and RTYPEEX. The IR is stable there.
//  - Reset in any state, incl. mid-fetch or in HALT: next state FETCH1 and no strobe asserted that cycle.
//  - Illegal state encodings recover to FETCH1 on the next clock.
// STRUCTURE
//  - mips_pkg: state enum (FETCH1..ADDIWR, HALT); opcode, funct, aluop and alucontrol localparams.
//  - One sub-module, mips_alu_decoder (aluop, funct -> alucontrol), purely combinational.
//  - FSM: one state register with sync reset, plus a next-state block and an output-decode block.
// TESTING
//  1. Reset held 2 cycles then released: 1st cycle irwrite=0001, pcen=1. irwrite walks 0010, 0100, 1000 over cycles 2-4.
//  2. LB (op=100000): states F1-F4, DECODE, MEMADR, LBRD, LBWR. iord=1 in LBRD. regwrite=1, memtoreg=1 only in cycle 8.
//  3. BEQ zero=1 -> pcen=1, pcsrc=01 in cycle 6. Repeat with zero=0 -> pcen=0 in cycle 6. Both return to FETCH1.
//  4. R-type funct 101010 -> alucontrol=111 in RTYPEEX. regwrite=1, regdst=1 in RTYPEWR.
//    Repeat for add, sub, and, or: 010, 110, 000, 001.
//  5. op=111111: ILLEGAL_TRAP=0 -> FETCH1 after DECODE, no strobes.
//    ILLEGAL_TRAP=1 -> halted=1 held 20 cycles, then cleared by reset.
//  6. Reset asserted in MEMADR of SB: memwrite never asserts. The next cycle is FETCH1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states,
// opcode/funct encodings, ALU operation classes and ALU control codes.
package mips_pkg;

    // Controller states; all sixteen 4-bit codes are assigned
    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14,
        S_HALT    = 4'd15
    } state_t;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation class requested by the FSM
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes seen by the datapath ALU
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the FSM's ALU operation class plus the R-type funct field to the
// 3-bit ALU control code. Unknown funct values fall back to add so the
// instruction still completes its write-back.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol
);

    // Select add/sub directly, or decode funct for register-register ops
    always_comb begin
        o_alucontrol = ALUCTL_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALUCTL_ADD;
            ALUOP_SUB: o_alucontrol = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alucontrol = ALUCTL_ADD;
                    FN_SUB:  o_alucontrol = ALUCTL_SUB;
                    FN_AND:  o_alucontrol = ALUCTL_AND;
                    FN_OR:   o_alucontrol = ALUCTL_OR;
                    FN_SLT:  o_alucontrol = ALUCTL_SLT;
                    default: o_alucontrol = ALUCTL_ADD;
                endcase
            end
            default: o_alucontrol = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle main controller for the 8-bit MIPS core. A Moore FSM fetches
// the instruction as four byte reads, decodes it, executes it and writes
// back, driving every datapath enable and mux select along the way.
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memwrite,
    output logic       pcen,
    output logic       iord,
    output logic       alusrcA,
    output logic [1:0] alusrcB,
    output logic [1:0] pcsrc,
    output logic [3:0] irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic [2:0] alucontrol,
    output logic       halted
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_decState;

    logic       w_memwrite;
    logic       w_pcwrite;
    logic       w_branch;
    logic [3:0] w_irwrite;
    logic       w_regwrite;
    logic [1:0] w_aluop;

    // State register; reset from any state lands in FETCH1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH1;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing; op is only consulted where the IR is stable
    always_comb begin
        w_next = S_FETCH1;
        case (r_state)
            S_FETCH1: w_next = S_FETCH2;
            S_FETCH2: w_next = S_FETCH3;
            S_FETCH3: w_next = S_FETCH4;
            S_FETCH4: w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LB, OP_SB: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_J:         w_next = S_JEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default:      w_next = ILLEGAL_TRAP ? S_HALT : S_FETCH1;
                endcase
            end
            S_MEMADR:  w_next = (op == OP_SB) ? S_SBWR : S_LBRD;
            S_LBRD:    w_next = S_LBWR;
            S_LBWR:    w_next = S_FETCH1;
            S_SBWR:    w_next = S_FETCH1;
            S_RTYPEEX: w_next = S_RTYPEWR;
            S_RTYPEWR: w_next = S_FETCH1;
            S_BEQEX:   w_next = S_FETCH1;
            S_JEX:     w_next = S_FETCH1;
            S_ADDIEX:  w_next = S_ADDIWR;
            S_ADDIWR:  w_next = S_FETCH1;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_FETCH1;
        endcase
    end

    // While reset is held the outputs show FETCH1 decode regardless of the
    // state currently registered
    assign w_decState = reset ? S_FETCH1 : r_state;

    // Moore output decode; everything not named for a state stays 0
    always_comb begin
        w_memwrite = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 4'b0000;
        w_regwrite = 1'b0;
        w_aluop    = ALUOP_ADD;
        iord       = 1'b0;
        alusrcA    = 1'b0;
        alusrcB    = 2'b00;
        pcsrc      = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        halted     = 1'b0;
        case (w_decState)
            S_FETCH1: begin
                alusrcB   = 2'b01;
                w_pcwrite = 1'b1;
                w_irwrite = 4'b0001;
            end
            S_FETCH2: begin
                alusrcB   = 2'b01;
                w_pcwrite = 1'b1;
                w_irwrite = 4'b0010;
            end
            S_FETCH3: begin
                alusrcB   = 2'b01;
                w_pcwrite = 1'b1;
                w_irwrite = 4'b0100;
            end
            S_FETCH4: begin
                alusrcB   = 2'b01;
                w_pcwrite = 1'b1;
                w_irwrite = 4'b1000;
            end
            S_DECODE: begin
                alusrcB = 2'b11;
            end
            S_MEMADR: begin
                alusrcA = 1'b1;
                alusrcB = 2'b10;
            end
            S_LBRD: begin
                iord = 1'b1;
            end
            S_LBWR: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
            end
            S_SBWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrcA = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            S_RTYPEWR: begin
                w_regwrite = 1'b1;
                regdst     = 1'b1;
            end
            S_BEQEX: begin
                alusrcA  = 1'b1;
                w_aluop  = ALUOP_SUB;
                w_branch = 1'b1;
                pcsrc    = 2'b01;
            end
            S_JEX: begin
                w_pcwrite = 1'b1;
                pcsrc     = 2'b10;
            end
            S_ADDIEX: begin
                alusrcA = 1'b1;
                alusrcB = 2'b10;
            end
            S_ADDIWR: begin
                w_regwrite = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    // Strobes that change architectural state are suppressed during reset
    assign memwrite = w_memwrite & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign irwrite  = reset ? 4'b0000 : w_irwrite;
    assign pcen     = (w_pcwrite | (w_branch & zero)) & ~reset;

    mips_alu_decoder u_aluDec (
        .i_aluop      (w_aluop),
        .i_funct      (funct),
        .o_alucontrol (alucontrol)
    );

endmodule
